// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode/state encodings and width defaults for alu_pipe
package alu_pipe_pkg;

    // Default datapath width tracks the CPU register file (REG_MSB + 1 bits).
    localparam int REG_MSB = 31;

    // Opcode 7 is SHR in the default build and MUL when ALU_PIPE_MUL_EN is defined.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_OR  = 3'd2,
        ALU_AND = 3'd3,
        ALU_NOT = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_OP7 = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/result handshake bundle between operand fetch, alu_pipe and writeback
// Request side : in_valid, in_ready, op1, op2, operation
// Result side  : out_valid, out_ready, res, C, Z, N, V, busy
// master = operand-fetch/writeback side, slave = alu_pipe.
interface alu_pipe_if import alu_pipe_pkg::*; #(
    parameter int WIDTH = REG_MSB + 1
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             C;
    logic             Z;
    logic             N;
    logic             V;
    logic             busy;

    modport master (
        output in_valid, op1, op2, operation, out_ready,
        input  in_ready, out_valid, res, C, Z, N, V, busy
    );

    modport slave (
        input  in_valid, op1, op2, operation, out_ready,
        output in_ready, out_valid, res, C, Z, N, V, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one partial product per cycle
// Ports: clk, reset_n (async active-low), start (load a/b), a, b,
//        done (product valid, held for one cycle), product[2*WIDTH-1:0].
// start must not be asserted while a multiply is running.
module alu_mul_seq import alu_pipe_pkg::*; #(
    parameter int WIDTH = REG_MSB + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;

    // done is raised once all WIDTH multiplier bits have been consumed.
    assign done    = run_q && (cnt_q == CNT_W'(WIDTH));
    assign product = acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (done) begin
                run_d = 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake, C/Z/N/V flags and optional multiply
// Ports: clk, reset_n (async active-low), bus (alu_pipe_if.slave: request in_valid/in_ready/
//        op1/op2/operation, result out_valid/out_ready/res/C/Z/N/V, busy).
// Macro ALU_PIPE_MUL_EN: opcode 7 becomes a WIDTH-cycle unsigned multiply instead of SHR.
module alu_pipe import alu_pipe_pkg::*; #(
    parameter int WIDTH   = REG_MSB + 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_pipe_if.slave  bus
);
    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic             out_valid_q, out_valid_d;

    alu_op_e          op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]   sum, diff, shl_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             in_ready, accept;
    logic             mul_sel, mul_done, mul_hi_nz;
    logic [WIDTH-1:0] mul_lo;

    assign op    = alu_op_e'(bus.operation);
    assign shamt = bus.op2[SHAMT_W-1:0];
    assign sum   = {1'b0, bus.op1} + {1'b0, bus.op2};
    // Bit WIDTH of the extended difference is the borrow.
    assign diff  = {1'b0, bus.op1} - {1'b0, bus.op2};
    // The extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_w = {1'b0, bus.op1} << shamt;

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_sel   = (op == ALU_OP7);
    assign mul_lo    = mul_prod[WIDTH-1:0];
    assign mul_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && mul_sel),
        .a       (bus.op1),
        .b       (bus.op2),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    logic [WIDTH:0] shr_w;

    // Extra bottom bit catches the last bit shifted out of the LSB end.
    assign shr_w     = {bus.op1, 1'b0} >> shamt;
    assign mul_sel   = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        alu_c   = c_q;
        alu_v   = v_q;
        case (op)
            ALU_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            ALU_OR:  alu_res = bus.op1 | bus.op2;
            ALU_AND: alu_res = bus.op1 & bus.op2;
            ALU_NOT: alu_res = ~bus.op1;
            ALU_XOR: alu_res = bus.op1 ^ bus.op2;
            ALU_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            ALU_OP7: begin
`ifndef ALU_PIPE_MUL_EN
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
`endif
            end
            default: alu_res = '0;
        endcase
    end

    // A new request is only taken when the output slot is free or draining this edge.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept && mul_sel) begin
                    state_d = ST_BUSY;
                end else if (accept) begin
                    res_d       = alu_res;
                    c_d         = alu_c;
                    v_d         = alu_v;
                    z_d         = (alu_res == '0);
                    n_d         = alu_res[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    res_d       = mul_lo;
                    c_d         = mul_hi_nz;
                    v_d         = mul_hi_nz;
                    z_d         = (mul_lo == '0);
                    n_d         = mul_lo[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            res_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.C         = c_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.V         = v_q;
`ifdef ALU_PIPE_MUL_EN
    assign bus.busy      = (state_q == ST_BUSY);
`else
    assign bus.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe at WIDTH=8
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic m_c = 1'b0;
    logic m_v = 1'b0;

    // Reference model; carries C/V forward for ops that leave them unchanged.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        logic [W-1:0]   r;
        logic [2*W-1:0] p;
        int             amt;
        int             s;
        amt = int'(b[2:0]);
        r   = '0;
        p   = '0;
        case (op)
            3'd0: begin
                s   = int'(a) + int'(b);
                r   = W'(s);
                m_c = (s >= (1 << W));
                m_v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                r   = a - b;
                m_c = (a < b);
                m_v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a | b;
            3'd3: r = a & b;
            3'd4: r = ~a;
            3'd5: r = a ^ b;
            3'd6: begin
                r   = a << amt;
                m_c = (amt == 0) ? 1'b0 : a[W-amt];
            end
            default: begin
`ifdef ALU_PIPE_MUL_EN
                p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r   = p[W-1:0];
                m_c = (p[2*W-1:W] != '0);
                m_v = m_c;
`else
                r   = a >> amt;
                m_c = (amt == 0) ? 1'b0 : a[amt-1];
`endif
            end
        endcase
        e.res = r;
        e.c   = m_c;
        e.z   = (r == '0);
        e.n   = r[W-1];
        e.v   = m_v;
        return e;
    endfunction

    function automatic logic [W+4:0] obs();
        return {bus.out_valid, bus.res, bus.C, bus.Z, bus.N, bus.V};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.op1       = a;
        bus.op2       = b;
        if (push) sb.push_back(model(op, a, b));
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 3'd0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b1;
        m_c = 1'b0;
        m_v = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs(), {(W+5){1'b0}});
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        exp_t e;
        int   lat;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(3'd0, 8'h7F, 8'h01, 1'b1);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (lat == 1) bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) break;
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL add_latency got=%0d want=1", lat);
        end
        e = sb.pop_front();
        checks++;
        if (obs() !== {1'b1, e}) begin
            failures++;
            $display("FAIL add_result got=%h want=%h", obs(), {1'b1, e});
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_valid_clear got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_sub_and();
        logic [2:0]   op[2] = '{3'd1, 3'd3};
        logic [W-1:0] a[2]  = '{8'h00, 8'hF0};
        logic [W-1:0] b[2]  = '{8'h01, 8'h0F};
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL sub_and[%0d] got=%h want=%h", i - 1, obs(), {1'b1, e});
                end
            end
            if (i < 2) drive(op[i], a[i], b[i], 1'b1);
            else bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_shift();
        logic [2:0]   op[6] = '{3'd0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
        logic [W-1:0] a[6]  = '{8'h7F, 8'h81, 8'h81, 8'h01, 8'hC0, 8'h81};
        logic [W-1:0] b[6]  = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h02, 8'h09};
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL shift[%0d] got=%h want=%h", i - 1, obs(), {1'b1, e});
                end
            end
            if (i < 6) drive(op[i], a[i], b[i], 1'b1);
            else bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_logic();
        logic [2:0]   op[6] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd5, 3'd3};
        logic [W-1:0] a[6]  = '{8'hFF, 8'h12, 8'h80, 8'h0F, 8'h3C, 8'hFF};
        logic [W-1:0] b[6]  = '{8'h01, 8'h40, 8'h01, 8'h00, 8'h3C, 8'h81};
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL logic[%0d] got=%h want=%h", i - 1, obs(), {1'b1, e});
                end
            end
            if (i < 6) drive(op[i], a[i], b[i], 1'b1);
            else bus.in_valid = 1'b0;
        end
    endtask

`ifndef ALU_PIPE_MUL_EN
    task automatic test_shr();
        logic [W-1:0] a[4] = '{8'h81, 8'h81, 8'h0C, 8'h80};
        logic [W-1:0] b[4] = '{8'h01, 8'h00, 8'h03, 8'h07};
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL shr[%0d] got=%h want=%h", i - 1, obs(), {1'b1, e});
                end
            end
            if (i < 4) drive(3'd7, a[i], b[i], 1'b1);
            else bus.in_valid = 1'b0;
        end
    endtask
`endif

    task automatic test_backpressure();
        exp_t e;
        exp_t held;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(3'd5, 8'hAA, 8'hFF, 1'b1);
        @(negedge clk);
        held = sb.pop_front();
        // Next request is presented while the output is stalled; it must not be taken.
        drive(3'd0, 8'h01, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs() !== {1'b1, held}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h want=%h", i, obs(), {1'b1, held});
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready[%0d] got=%b want=0", i, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        sb.push_back(model(3'd0, 8'h01, 8'h02));
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs() !== {1'b1, e}) begin
            failures++;
            $display("FAIL bp_queued got=%h want=%h", obs(), {1'b1, e});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a[4] = '{8'h01, 8'h10, 8'hFF, 8'h80};
        logic [W-1:0] b[4] = '{8'h02, 8'h20, 8'hFF, 8'h80};
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL b2b[%0d] got=%h want=%h", i - 1, obs(), {1'b1, e});
                end
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, bus.in_ready);
            end
            if (i < 4) drive(3'd0, a[i], b[i], 1'b1);
            else bus.in_valid = 1'b0;
        end
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        logic [W-1:0] a[2] = '{8'h10, 8'h03};
        logic [W-1:0] b[2] = '{8'h11, 8'h05};
        exp_t e;
        int   lat;
        bit   seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(3'd7, a[i], b[i], 1'b1);
            for (lat = 1; lat <= 30; lat++) begin
                @(negedge clk);
                if (lat == 1) begin
                    bus.in_valid = 1'b0;
                    checks++;
                    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL mul_busy[%0d] got busy=%b in_ready=%b want busy=1 in_ready=0",
                                 i, bus.busy, bus.in_ready);
                    end
                end
                if (bus.out_valid === 1'b1) break;
            end
            checks++;
            if (lat !== W + 1) begin
                failures++;
                $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, W + 1);
            end
            e = sb.pop_front();
            checks++;
            if (obs() !== {1'b1, e}) begin
                failures++;
                $display("FAIL mul_result[%0d] got=%h want=%h", i, obs(), {1'b1, e});
            end
        end
        // Reset in the middle of a multiply: everything clears and nothing is emitted.
        @(negedge clk);
        drive(3'd7, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mul_abort_busy got=%b want=1", bus.busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_abort_clear got=%h busy=%b want=%h busy=0", obs(), bus.busy, {(W+5){1'b0}});
        end
        m_c = 1'b0;
        m_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (W + 6) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_abort_no_output got seen=%b in_ready=%b want seen=0 in_ready=1", seen, bus.in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_and();
        test_shift();
        test_logic();
`ifndef ALU_PIPE_MUL_EN
        test_shr();
`endif
        test_backpressure();
        test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
